// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//   Instruction prefetch queue sitting directly upstream of the IF stage.
//   Fetches sequential words from a handshaked instruction memory into a
//   small circular FIFO of {PC, instruction} pairs and presents the head
//   entry to IF. A redirect from ID flushes the queue. If a fetch is still
//   outstanding at the redirect, that fetch is drained and its data dropped.
//
// Parameters
//   DEPTH     queue entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   CLK            in   clock, rising edge
//   RESET          in   asynchronous active-low reset
//   mem_req        out  fetch request to instruction memory
//   mem_addr       out  fetch address, word aligned, stable while mem_req=1
//   mem_ack        in   memory accepted the request, mem_rdata valid this cycle
//   mem_rdata      in   fetched instruction
//   Redirect       in   1-cycle pulse, branch/jump taken in ID
//   Redirect_PC    in   new fetch address (bits [1:0] ignored)
//   IF_Ready       in   IF consumes the head entry this cycle
//   IF_Valid       out  head entry valid
//   IF_Instruction out  head instruction (0 when empty)
//   IF_PC          out  head instruction address (0 when empty)
//   IF_Count       out  entries currently held
// -----------------------------------------------------------------------------
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    input  logic        IF_Ready,
    output logic        IF_Valid,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [2:0]  IF_Count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [31:0]     fetch_pc_r;
    logic [31:0]     mem_addr_r;
    logic            mem_req_r;
    logic [31:0]     pc_q_r    [DEPTH];
    logic [31:0]     instr_q_r [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic [CW-1:0]   count_nxt_s;
    logic            slot_free_s;
    logic [31:0]     redirect_pc_s;
    logic [31:0]     fetch_pc_inc_s;

    // Handshake decode and next-occupancy used for the issue decision
    always_comb begin
        pop_s          = (count_r != {CW{1'b0}}) && IF_Ready;
        // Only a live (non-draining) request pushes; a redirect discards it
        push_s         = (state_r == ST_REQ) && mem_ack && !Redirect;
        count_nxt_s    = count_r + CW'(push_s) - CW'(pop_s);
        // A new request is allowed only if its data is sure to find a slot
        slot_free_s    = (count_nxt_s < CW'(DEPTH));
        redirect_pc_s  = {Redirect_PC[31:2], 2'b00};
        fetch_pc_inc_s = fetch_pc_r + 32'd4;
    end

    // Fetch FSM, occupancy, pointers and registered memory-side outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            fetch_pc_r <= RESET_PC;
            mem_addr_r <= RESET_PC;
            mem_req_r  <= 1'b0;
        end else if (Redirect) begin
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            fetch_pc_r <= redirect_pc_s;
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_REQ;
                    mem_req_r  <= 1'b1;
                    mem_addr_r <= redirect_pc_s;
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= redirect_pc_s;
                    end else begin
                        // Old request must complete at its old address
                        state_r    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= redirect_pc_s;
                    end else begin
                        state_r    <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (slot_free_s) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= fetch_pc_r;
                    end else begin
                        state_r    <= ST_IDLE;
                        mem_req_r  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        fetch_pc_r <= fetch_pc_inc_s;
                        mem_addr_r <= fetch_pc_inc_s;
                        if (slot_free_s) begin
                            state_r   <= ST_REQ;
                            mem_req_r <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            mem_req_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Drained data is dropped; queue is empty so a slot is free
                    if (mem_ack) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= fetch_pc_r;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Queue storage written on each accepted fetch
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= 32'h0000_0000;
                instr_q_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_q_r[wr_ptr_r]    <= fetch_pc_r;
            instr_q_r[wr_ptr_r] <= mem_rdata;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= pc_q_r[i];
                instr_q_r[i] <= instr_q_r[i];
            end
        end
    end

    // Head presentation to IF, forced to zero when the queue is empty
    always_comb begin
        if (count_r != {CW{1'b0}}) begin
            IF_Valid       = 1'b1;
            IF_Instruction = instr_q_r[rd_ptr_r];
            IF_PC          = pc_q_r[rd_ptr_r];
        end else begin
            IF_Valid       = 1'b0;
            IF_Instruction = 32'h0000_0000;
            IF_PC          = 32'h0000_0000;
        end
        IF_Count = 3'(count_r);
        mem_req  = mem_req_r;
        mem_addr = mem_addr_r;
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch_queue
//   Self-checking bench for inst_prefetch_queue. A queue-based behavioural
//   model tracks the FIFO contents, the next fetch address and whether an
//   abandoned request is still being drained; a negedge process compares all
//   outputs against it every cycle. Directed scenarios pin the model with
//   literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RESET;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        IF_Ready;
    logic        IF_Valid;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic [2:0]  IF_Count;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .Redirect       (Redirect),
        .Redirect_PC    (Redirect_PC),
        .IF_Ready       (IF_Ready),
        .IF_Valid       (IF_Valid),
        .IF_Instruction (IF_Instruction),
        .IF_PC          (IF_PC),
        .IF_Count       (IF_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [63:0] mq[$];          // {pc, instr}
    logic [31:0] m_fetch;
    logic        m_req;
    logic        m_drain;
    logic [31:0] m_drain_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch      = 32'h0000_0000;
        m_req        = 1'b0;
        m_drain      = 1'b0;
        m_drain_addr = 32'h0000_0000;
    endtask

    // Apply one rising edge worth of spec rules to the model
    task automatic model_edge();
        if (RESET == 1'b0) begin
            model_reset();
        end else begin
            if (Redirect) begin
                if (m_req && !mem_ack && !m_drain) begin
                    m_drain      = 1'b1;
                    m_drain_addr = m_fetch;
                end else if (m_drain && mem_ack) begin
                    m_drain = 1'b0;
                end
                mq.delete();
                m_fetch = {Redirect_PC[31:2], 2'b00};
            end else begin
                if (mq.size() > 0 && IF_Ready) void'(mq.pop_front());
                if (m_req && mem_ack) begin
                    if (m_drain) begin
                        m_drain = 1'b0;
                    end else begin
                        mq.push_back({m_fetch, mem_rdata});
                        m_fetch = m_fetch + 32'd4;
                    end
                end
            end
            m_req = m_drain || (mq.size() < DEPTH);
        end
    endtask

    // Drive one cycle of inputs, then advance past the edge
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic rdr,
                       input logic [31:0] rpc, input logic rdy);
        mem_ack     = ack;
        mem_rdata   = rd;
        Redirect    = rdr;
        Redirect_PC = rpc;
        IF_Ready    = rdy;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        logic [63:0] head;
        head = (mq.size() > 0) ? mq[0] : 64'h0;
        chk("mem_req", {31'h0, mem_req}, {31'h0, m_req});
        if (m_req) chk("mem_addr", mem_addr, m_drain ? m_drain_addr : m_fetch);
        chk("IF_Valid", {31'h0, IF_Valid}, {31'h0, (mq.size() > 0)});
        chk("IF_PC", IF_PC, head[63:32]);
        chk("IF_Instruction", IF_Instruction, head[31:0]);
        chk("IF_Count", {29'h0, IF_Count}, 32'(mq.size()));
    end

    initial begin
        RESET       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        Redirect    = 1'b0;
        Redirect_PC = 32'h0;
        IF_Ready    = 1'b0;
        model_reset();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_count", {29'h0, IF_Count}, 32'h0);
        RESET = 1'b1;

        // 1: fill with ack tied high, no consumption
        cyc(1'b1, 32'h1000_0000, 1'b0, 32'h0, 1'b0);
        chk("t1_first_req", {31'h0, mem_req}, 32'h1);
        chk("t1_first_addr", mem_addr, 32'h0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
        chk("t1_count", {29'h0, IF_Count}, 32'h4);
        chk("t1_req_off", {31'h0, mem_req}, 32'h0);
        chk("t1_head_pc", IF_PC, 32'h0);
        chk("t1_head_instr", IF_Instruction, 32'h1000_0001);

        // 2: single pop from full
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t2_head_pc", IF_PC, 32'h4);
        chk("t2_req", {31'h0, mem_req}, 32'h1);
        chk("t2_addr", mem_addr, 32'h10);
        cyc(1'b1, 32'h2000_0010, 1'b0, 32'h0, 1'b0);
        chk("t2_refill", {29'h0, IF_Count}, 32'h4);

        // 3: redirect from IDLE, then stream one entry per cycle
        cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        chk("t3_addr", mem_addr, 32'h200);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 32'h3000_0000 + 32'(k), 1'b0, 32'h0, 1'b1);
            chk("t3_valid", {31'h0, IF_Valid}, 32'h1);
            chk("t3_pc", IF_PC, 32'h200 + 32'(4 * k));
        end

        // 4: redirect while a request at 0x8 waits on a slow memory
        cyc(1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
        cyc(1'b1, 32'hBAD0_0000, 1'b0, 32'h0, 1'b0);
        chk("t4_addr8", mem_addr, 32'h8);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        chk("t4_hold_req", {31'h0, mem_req}, 32'h1);
        chk("t4_hold_addr", mem_addr, 32'h8);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_hold_addr2", mem_addr, 32'h8);
        cyc(1'b1, 32'hBAD0_0008, 1'b0, 32'h0, 1'b0);
        chk("t4_dropped", {29'h0, IF_Count}, 32'h0);
        chk("t4_new_addr", mem_addr, 32'h100);
        cyc(1'b1, 32'h4000_0100, 1'b0, 32'h0, 1'b0);
        chk("t4_valid", {31'h0, IF_Valid}, 32'h1);
        chk("t4_pc", IF_PC, 32'h100);
        chk("t4_instr", IF_Instruction, 32'h4000_0100);

        // 5: redirect coincident with ack, misaligned target
        cyc(1'b1, 32'hBAD0_0104, 1'b1, 32'h303, 1'b0);
        chk("t5_count", {29'h0, IF_Count}, 32'h0);
        chk("t5_addr", mem_addr, 32'h300);
        chk("t5_req", {31'h0, mem_req}, 32'h1);

        // 6: asynchronous reset during an active request
        RESET = 1'b0;
        model_reset();
        #1;
        chk("t6_req", {31'h0, mem_req}, 32'h0);
        chk("t6_addr", mem_addr, 32'h0);
        chk("t6_valid", {31'h0, IF_Valid}, 32'h0);
        chk("t6_pc", IF_PC, 32'h0);
        chk("t6_instr", IF_Instruction, 32'h0);
        chk("t6_count", {29'h0, IF_Count}, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        RESET = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                $urandom,
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                $urandom,
                $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
        end

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
